// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage PC sequencer with IF/ID register, branch redirect, stall/halt and perf counters
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter bit          DELAY_SLOT = 1'b1,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [63:0]      br_pc,
  input  logic             halt,
  input  logic [31:0]      mem_instr,
  output logic [63:0]      pc,
  output logic [31:0]      ifid_instr,
  output logic [63:0]      ifid_pc,
  output logic             ifid_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t           state_q;
  logic [63:0]      pc_q, ifid_pc_q;
  logic [31:0]      ifid_instr_q;
  logic             ifid_valid_q, halted_q;
  logic [CNT_W-1:0] fetch_cnt_q, bubble_cnt_q, fetch_cnt_d, bubble_cnt_d;
  logic             squash;
  // Saturating increments so the counters stick at all-ones instead of wrapping
  always_comb begin
    fetch_cnt_d  = &fetch_cnt_q ? fetch_cnt_q : fetch_cnt_q + CNT_W'(1);
    bubble_cnt_d = &bubble_cnt_q ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);
    squash       = br_taken && !DELAY_SLOT;
  end
  // BOOT/RUN/HALT sequencer owning the PC, IF/ID register and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q      <= RUN;
          ifid_valid_q <= 1'b0;
        end
        RUN: begin
          if (halt) begin
            state_q      <= HALT;
            halted_q     <= 1'b1;
            ifid_valid_q <= 1'b0;
          end else if (stall) begin
            bubble_cnt_q <= bubble_cnt_d;
          end else begin
            pc_q         <= br_taken ? {br_pc[63:2], 2'b00} : pc_q + 64'd4;
            ifid_pc_q    <= pc_q;
            ifid_instr_q <= squash ? 32'h0 : mem_instr;
            ifid_valid_q <= !squash;
            if (squash) bubble_cnt_q <= bubble_cnt_d;
            else fetch_cnt_q <= fetch_cnt_d;
          end
        end
        HALT: ifid_valid_q <= 1'b0;
        default: state_q <= BOOT;
      endcase
    end
  end
  assign pc         = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = halted_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch_sequencer (default build, plus a wrap/squash/saturation build)
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_a = 1'b0, stall_a = 1'b0, br_a = 1'b0, halt_a = 1'b0;
  logic [63:0] brpc_a = '0;
  logic [31:0] mem_a, ifid_instr_a;
  logic [63:0] pc_a, ifid_pc_a;
  logic        valid_a, halted_a;
  logic [31:0] fcnt_a, bcnt_a;
  logic        rst_b = 1'b0, stall_b = 1'b0, br_b = 1'b0, halt_b = 1'b0;
  logic [63:0] brpc_b = '0;
  logic [31:0] mem_b, ifid_instr_b;
  logic [63:0] pc_b, ifid_pc_b;
  logic        valid_b, halted_b;
  logic [2:0]  fcnt_b, bcnt_b;
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] imem(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction
  assign mem_a = imem(pc_a);
  assign mem_b = imem(pc_b);
  fetch_sequencer u_a (
    .clk(clk), .reset(rst_a), .stall(stall_a), .br_taken(br_a), .br_pc(brpc_a), .halt(halt_a),
    .mem_instr(mem_a), .pc(pc_a), .ifid_instr(ifid_instr_a), .ifid_pc(ifid_pc_a),
    .ifid_valid(valid_a), .halted(halted_a), .fetch_cnt(fcnt_a), .bubble_cnt(bcnt_a)
  );
  fetch_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .DELAY_SLOT(1'b0), .CNT_W(3)) u_b (
    .clk(clk), .reset(rst_b), .stall(stall_b), .br_taken(br_b), .br_pc(brpc_b), .halt(halt_b),
    .mem_instr(mem_b), .pc(pc_b), .ifid_instr(ifid_instr_b), .ifid_pc(ifid_pc_b),
    .ifid_valid(valid_b), .halted(halted_b), .fetch_cnt(fcnt_b), .bubble_cnt(bcnt_b)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    step(2);
    check("rst_pc", pc_a, 64'h0);
    check("rst_valid", valid_a, 0);
    check("rst_halted", halted_a, 0);
    check("rst_fcnt", fcnt_a, 0);
    check("rst_bcnt", bcnt_a, 0);
    rst_a = 1'b1;
    step();
    check("boot_pc", pc_a, 64'h0);
    check("boot_valid", valid_a, 0);
    step();
    check("run1_pc", pc_a, 64'h4);
    check("run1_ipc", ifid_pc_a, 64'h0);
    check("run1_instr", ifid_instr_a, imem(64'h0));
    check("run1_valid", valid_a, 1);
    step();
    check("run2_pc", pc_a, 64'h8);
    check("run2_ipc", ifid_pc_a, 64'h4);
    step();
    check("run3_pc", pc_a, 64'hC);
    check("run3_ipc", ifid_pc_a, 64'h8);
    check("run3_fcnt", fcnt_a, 3);
    step();
    check("run4_pc", pc_a, 64'h10);
    br_a = 1'b1; brpc_a = 64'h103;
    step();
    br_a = 1'b0;
    check("br_pc", pc_a, 64'h100);
    check("br_ipc", ifid_pc_a, 64'h10);
    check("br_instr", ifid_instr_a, imem(64'h10));
    check("br_valid", valid_a, 1);
    check("br_fcnt", fcnt_a, 5);
    check("br_bcnt", bcnt_a, 0);
    stall_a = 1'b1; br_a = 1'b1; brpc_a = 64'h200;
    step(2);
    check("stall_pc", pc_a, 64'h100);
    check("stall_ipc", ifid_pc_a, 64'h10);
    check("stall_bcnt", bcnt_a, 2);
    check("stall_fcnt", fcnt_a, 5);
    stall_a = 1'b0; br_a = 1'b0;
    step();
    check("unstall_pc", pc_a, 64'h104);
    check("unstall_ipc", ifid_pc_a, 64'h100);
    br_a = 1'b1; brpc_a = 64'h20;
    step();
    br_a = 1'b0;
    check("to20_pc", pc_a, 64'h20);
    halt_a = 1'b1;
    step();
    halt_a = 1'b0; br_a = 1'b1; brpc_a = 64'h300; stall_a = 1'b1;
    check("halt_halted", halted_a, 1);
    check("halt_pc", pc_a, 64'h20);
    check("halt_valid", valid_a, 0);
    step(3);
    check("halt3_pc", pc_a, 64'h20);
    check("halt3_valid", valid_a, 0);
    check("halt3_halted", halted_a, 1);
    check("halt3_bcnt", bcnt_a, 2);
    check("halt3_fcnt", fcnt_a, 7);
    br_a = 1'b0; stall_a = 1'b0;
    rst_a = 1'b0;
    #1;
    check("hrst_pc", pc_a, 64'h0);
    check("hrst_halted", halted_a, 0);
    rst_a = 1'b1;
    step();
    check("hboot_pc", pc_a, 64'h0);
    check("hboot_valid", valid_a, 0);
    step();
    check("hrun_pc", pc_a, 64'h4);
    stall_a = 1'b1;
    step();
    check("pre_arst_bcnt", bcnt_a, 1);
    #2 rst_a = 1'b0;
    #1;
    check("arst_pc", pc_a, 64'h0);
    check("arst_ipc", ifid_pc_a, 64'h0);
    check("arst_instr", ifid_instr_a, 0);
    check("arst_valid", valid_a, 0);
    check("arst_fcnt", fcnt_a, 0);
    check("arst_bcnt", bcnt_a, 0);
    stall_a = 1'b0;
    rst_b = 1'b1;
    step();
    check("b_boot_pc", pc_b, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    check("b_wrap1", pc_b, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("b_wrap2", pc_b, 64'h0);
    step();
    check("b_wrap3", pc_b, 64'h4);
    check("b_fcnt3", fcnt_b, 3);
    br_b = 1'b1; brpc_b = 64'h103;
    step();
    br_b = 1'b0;
    check("b_sq_pc", pc_b, 64'h100);
    check("b_sq_valid", valid_b, 0);
    check("b_sq_instr", ifid_instr_b, 0);
    check("b_sq_bcnt", bcnt_b, 1);
    check("b_sq_fcnt", fcnt_b, 3);
    step(6);
    check("b_fsat", fcnt_b, 7);
    stall_b = 1'b1;
    step(8);
    stall_b = 1'b0;
    check("b_bsat", bcnt_b, 7);
    step(2);
    check("b_fsat_hold", fcnt_b, 7);
    check("b_bsat_hold", bcnt_b, 7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
